// File: rtl/memory_access_stage_pkg.sv
// Shared types and constants for the CPU memory stage (package cpu_mem_pkg).
package cpu_mem_pkg;

  localparam int          DEFAULT_DATA_W = 16;
  localparam logic [15:0] TIMEOUT_DATA   = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic wbs;
    logic ni;
  } wb_ctrl_t;

  // Control word loaded into the writeback register while the stage is stalled.
  localparam wb_ctrl_t BUBBLE = '{wbs: 1'b0, ni: 1'b1};

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
interface memory_access_stage_if #(
  parameter int DATA_W = 16
);
  // Handshake: master raises mem_req with mem_we/mem_addr/mem_wdata stable and
  // holds them until the slave returns a single-cycle mem_ack (with mem_rdata
  // valid on that same edge); mem_req drops on the edge that samples mem_ack.
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_watchdog.sv
// Ack-wait timeout counter and sticky error flag for the memory stage.
module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_wait,
  input  logic ack,
  output logic timeout,
  output logic err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // An ack on the final allowed cycle still wins over the timeout.
  assign timeout = in_wait && !ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (start) begin
        cnt <= '0;
      end else if (in_wait) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (timeout) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage of the 16-bit pipelined CPU: load/store over a req/ack memory bus.
// Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
module memory_access_stage
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wbs_in,
  input  logic [DATA_W-1:0]            calcData_in,
  input  logic [DATA_W-1:0]            wdata_in,
  input  logic                         re_in,
  input  logic                         we_in,
  input  logic                         ni_in,
  output logic                         stall_out,
  memory_access_stage_if.master        mem,
  output logic                         wbs_out,
  output logic [DATA_W-1:0]            memData_out,
  output logic [DATA_W-1:0]            calcData_out,
  output logic                         ni_out,
  output logic                         err_out,
  output mem_state_t                   state_dbg
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]        state;
  logic [DATA_W-1:0] rdata_q;
  logic              access;
  logic              timeout;

  assign access    = !ni_in && (re_in || we_in);
  assign stall_out = !rst && (((state == S_IDLE) && access) || (state == S_WAIT));
  assign state_dbg = mem_state_t'(state);

`ifdef MEM_TIMEOUT_EN
  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .start  ((state == S_IDLE) && access),
    .in_wait(state == S_WAIT),
    .ack    (mem.mem_ack),
    .timeout(timeout),
    .err    (err_out)
  );
`else
  assign timeout = 1'b0;
  assign err_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      rdata_q       <= '0;
      wbs_out       <= 1'b0;
      memData_out   <= '0;
      calcData_out  <= '0;
      ni_out        <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            state         <= S_WAIT;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= we_in;
            mem.mem_addr  <= calcData_in;
            mem.mem_wdata <= wdata_in;
            wbs_out       <= BUBBLE.wbs;
            ni_out        <= BUBBLE.ni;
          end else begin
            wbs_out      <= wbs_in;
            calcData_out <= calcData_in;
            memData_out  <= '0;
            ni_out       <= ni_in;
          end
        end
        S_WAIT: begin
          wbs_out <= BUBBLE.wbs;
          ni_out  <= BUBBLE.ni;
          if (mem.mem_ack) begin
            if (!mem.mem_we) begin
              rdata_q <= mem.mem_rdata;
            end
            state       <= S_DONE;
            mem.mem_req <= 1'b0;
          end else if (timeout) begin
            rdata_q     <= DATA_W'(TIMEOUT_DATA);
            state       <= S_DONE;
            mem.mem_req <= 1'b0;
          end
        end
        S_DONE: begin
          // Upstream is frozen, so the inputs still describe this instruction.
          wbs_out      <= wbs_in;
          calcData_out <= calcData_in;
          ni_out       <= 1'b0;
          memData_out  <= mem.mem_we ? '0 : rdata_q;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed table, reset/timeout
// sequences and randomized instructions against a transaction-level model.
module tb_memory_access_stage;
  import cpu_mem_pkg::*;

  localparam int W  = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wbs_in, re_in, we_in, ni_in;
  logic [W-1:0]  calcData_in, wdata_in;
  logic          stall_out, wbs_out, ni_out, err_out;
  logic [W-1:0]  memData_out, calcData_out;
  mem_state_t    state_dbg;

  memory_access_stage_if #(.DATA_W(W)) mem_if ();

  memory_access_stage #(
    .DATA_W        (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wbs_in      (wbs_in),
    .calcData_in (calcData_in),
    .wdata_in    (wdata_in),
    .re_in       (re_in),
    .we_in       (we_in),
    .ni_in       (ni_in),
    .stall_out   (stall_out),
    .mem         (mem_if.master),
    .wbs_out     (wbs_out),
    .memData_out (memData_out),
    .calcData_out(calcData_out),
    .ni_out      (ni_out),
    .err_out     (err_out),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "time budget exceeded");
  end

  typedef struct {
    logic         wbs;
    logic [W-1:0] calc;
    logic [W-1:0] wdata;
    logic         re;
    logic         we;
    logic         ni;
    int           ack_dly;
    logic         no_ack;
    logic [W-1:0] rdata;
    logic [W-1:0] exp_mem;
    int           exp_stalls;
  } vec_t;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] prev_calc = '0;
  logic [W-1:0] prev_mem  = '0;
  logic         exp_err   = 1'b0;
  vec_t         tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic wbs, input logic [W-1:0] calc, input logic [W-1:0] wdata,
                              input logic re, input logic we, input logic ni, input int dly,
                              input logic no_ack, input logic [W-1:0] rdata,
                              input logic [W-1:0] exp_mem, input int exp_stalls);
    vec_t v;
    v.wbs = wbs; v.calc = calc; v.wdata = wdata; v.re = re; v.we = we; v.ni = ni;
    v.ack_dly = dly; v.no_ack = no_ack; v.rdata = rdata;
    v.exp_mem = exp_mem; v.exp_stalls = exp_stalls;
    return v;
  endfunction

  // Reference model: what one instruction should deliver, from the stage's rules.
  function automatic vec_t with_expect(input vec_t v);
    vec_t r;
    logic acc;
    r   = v;
    acc = !v.ni && (v.re || v.we);
    if (!acc) begin
      r.exp_mem    = '0;
      r.exp_stalls = 0;
    end else begin
      r.exp_stalls = (v.no_ack ? TO : v.ack_dly) + 1;
      if (v.we)          r.exp_mem = '0;
      else if (v.no_ack) r.exp_mem = TIMEOUT_DATA;
      else               r.exp_mem = v.rdata;
    end
    return r;
  endfunction

  // driver: called at a negedge; returns at the negedge where the result is checked
  task automatic run_instr(input vec_t v);
    logic acc;
    int   stalls;
    int   dly;
    acc         = !v.ni && (v.re || v.we);
    wbs_in      = v.wbs;
    calcData_in = v.calc;
    wdata_in    = v.wdata;
    re_in       = v.re;
    we_in       = v.we;
    ni_in       = v.ni;
    mem_if.mem_ack   = 1'($urandom_range(0, 1));
    mem_if.mem_rdata = W'($urandom);
    exp_q.push_back(v.exp_mem);
    #1;
    stalls = int'(stall_out);
    chk("stall_accept", stall_out, acc);
    if (acc) begin
      dly = v.no_ack ? TO : v.ack_dly;
      for (int k = 1; k <= dly; k++) begin
        @(negedge clk);
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = W'($urandom);
        #1;
        chk("wait_req",   mem_if.mem_req, 1'b1);
        chk("wait_addr",  mem_if.mem_addr, v.calc);
        chk("wait_we",    mem_if.mem_we, v.we);
        chk("wait_wdata", mem_if.mem_wdata, v.wdata);
        chk("wait_ni",    ni_out, 1'b1);
        chk("wait_wbs",   wbs_out, 1'b0);
        chk("wait_calc",  calcData_out, prev_calc);
        chk("wait_mem",   memData_out, prev_mem);
        stalls += int'(stall_out);
        if (k == dly && !v.no_ack) begin
          mem_if.mem_ack   = 1'b1;
          mem_if.mem_rdata = v.rdata;
        end
      end
      @(negedge clk);
      mem_if.mem_ack = 1'($urandom_range(0, 1));
      #1;
      chk("done_req", mem_if.mem_req, 1'b0);
      chk("done_ni",  ni_out, 1'b1);
      stalls += int'(stall_out);
    end
    @(negedge clk);
    mem_if.mem_ack = 1'b0;
    exp_err = exp_err | (acc & v.no_ack);
    chk("out_wbs",    wbs_out, v.wbs);
    chk("out_calc",   calcData_out, v.calc);
    chk("out_ni",     ni_out, acc ? 1'b0 : v.ni);
    chk("out_mem",    memData_out, exp_q.pop_front());
    chk("out_err",    err_out, exp_err);
    chk("out_req",    mem_if.mem_req, 1'b0);
    chk("stall_count", stalls, v.exp_stalls);
    prev_calc = v.calc;
    prev_mem  = memData_out;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    wbs_in = 1'b0; calcData_in = '0; wdata_in = '0;
    re_in = 1'b0; we_in = 1'b0; ni_in = 1'b0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_wbs",   wbs_out, 1'b0);
    chk("rst_mem",   memData_out, 16'h0000);
    chk("rst_calc",  calcData_out, 16'h0000);
    chk("rst_ni",    ni_out, 1'b1);
    chk("rst_err",   err_out, 1'b0);
    chk("rst_req",   mem_if.mem_req, 1'b0);
    chk("rst_we",    mem_if.mem_we, 1'b0);
    chk("rst_addr",  mem_if.mem_addr, 16'h0000);
    chk("rst_wdata", mem_if.mem_wdata, 16'h0000);
    chk("rst_stall", stall_out, 1'b0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;

    // wbs, calc, wdata, re, we, ni, ack_dly, no_ack, rdata, exp_mem, exp_stalls
    tbl[0] = mk(1'b1, 16'hABCD, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 1'b0, 16'h0000, 16'h0000, 0);
    tbl[1] = mk(1'b1, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 3, 1'b0, 16'h1234, 16'h1234, 4);
    tbl[2] = mk(1'b0, 16'h0020, 16'h5678, 1'b1, 1'b1, 1'b0, 1, 1'b0, 16'h9999, 16'h0000, 2);
    tbl[3] = mk(1'b1, 16'h0030, 16'h0000, 1'b1, 1'b0, 1'b1, 1, 1'b0, 16'h7777, 16'h0000, 0);
    tbl[4] = mk(1'b0, 16'h0040, 16'hC0DE, 1'b0, 1'b1, 1'b0, 2, 1'b0, 16'h4444, 16'h0000, 3);
    tbl[5] = mk(1'b1, 16'h0050, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 1'b0, 16'hBEEF, 16'hBEEF, 2);
    tbl[6] = mk(1'b1, 16'h0060, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 1'b0, 16'h0F0F, 16'h0F0F, 2);
    tbl[7] = mk(1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 1'b0, 16'h0000, 16'h0000, 0);
    for (int i = 0; i < 8; i++) run_instr(tbl[i]);

    // reset during WAIT abandons the access; a stray ack afterwards is ignored
    wbs_in = 1'b1; calcData_in = 16'h0042; re_in = 1'b1; we_in = 1'b0; ni_in = 1'b0;
    @(negedge clk);
    chk("rstmid_req_before", mem_if.mem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    wbs_in = 1'b0; calcData_in = '0; re_in = 1'b0; ni_in = 1'b1;
    @(negedge clk);
    chk("rstmid_req",   mem_if.mem_req, 1'b0);
    chk("rstmid_stall", stall_out, 1'b0);
    chk("rstmid_ni",    ni_out, 1'b1);
    chk("rstmid_err",   err_out, 1'b0);
    rst = 1'b0;
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'hBAD0;
    @(negedge clk);
    mem_if.mem_ack = 1'b0;
    chk("stray_req",   mem_if.mem_req, 1'b0);
    chk("stray_state", 32'(state_dbg), 32'(IDLE));
    chk("stray_mem",   memData_out, 16'h0000);
    chk("stray_ni",    ni_out, 1'b1);
    prev_calc = '0;
    prev_mem  = '0;
    exp_err   = 1'b0;
    run_instr(mk(1'b1, 16'h0070, 16'h0000, 1'b1, 1'b0, 1'b0, 2, 1'b0, 16'h1111, 16'h1111, 3));

`ifdef MEM_TIMEOUT_EN
    run_instr(with_expect(mk(1'b1, 16'h0080, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 1'b1, 16'h0000, 16'h0000, 0)));
    chk("timeout_mem", memData_out, TIMEOUT_DATA);
    run_instr(with_expect(mk(1'b1, 16'h0090, 16'h0000, 1'b1, 1'b0, 1'b0, 2, 1'b0, 16'h2222, 16'h0000, 0)));
    chk("err_sticky", err_out, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      v.wbs     = 1'($urandom);
      v.calc    = W'($urandom);
      v.wdata   = W'($urandom);
      v.re      = 1'($urandom_range(0, 1));
      v.we      = 1'($urandom_range(0, 1));
      v.ni      = ($urandom_range(0, 3) == 0);
      v.ack_dly = $urandom_range(1, TO);
      v.no_ack  = 1'b0;
      v.rdata   = W'($urandom);
      run_instr(with_expect(v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory stage of the 16-bit pipelined CPU: the producer side of the memory/writeback register. It takes the EX/MEM stage outputs, performs load/store accesses on a multi-cycle data memory with a req/ack handshake, and presents registered `wbs_out`, `memData_out`, `calcData_out` and `ni_out` to the writeback register. While an access is outstanding it freezes the upstream pipeline and issues bubbles (`ni_out=1`) downstream.

## Interface
- `DATA_W`, 16: data and address width.
- `TIMEOUT_CYCLES`, 16: ack wait limit, used only when the watchdog is compiled in.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `wbs_in` in 1: writeback select from EX/MEM.
- `calcData_in` in DATA_W: ALU result; also the memory address.
- `wdata_in` in DATA_W: store data.
- `re_in` in 1: load request.
- `we_in` in 1: store request.
- `ni_in` in 1: no-instruction (bubble) flag.
- `stall_out` out 1: freezes PC, IF/ID, ID/EX and EX/MEM when high.
- `mem_req` out 1: memory request, registered.
- `mem_we` out 1: write strobe qualifying `mem_req`.
- `mem_addr` out DATA_W: latched address.
- `mem_wdata` out DATA_W: latched store data.
- `mem_rdata` in DATA_W: read data, valid when `mem_ack` is high.
- `mem_ack` in 1: one-cycle completion pulse.
- `wbs_out`, `memData_out`, `calcData_out`, `ni_out` out 1/DATA_W/DATA_W/1: registered outputs to the writeback register.
- `err_out` out 1: sticky timeout flag.

## Operation
- **FSM states:** IDLE, WAIT, DONE.
- **Access detection:** an access is `ni_in=0 & (re_in | we_in)`. If `re_in` and `we_in` are both high, the access is a store.
- **IDLE, no access:**
  - Output regs load `wbs_in`, `calcData_in` and `ni_in`; `memData_out` loads 0.
  - `stall_out=0`.
- **IDLE, access:**
  - Latch `mem_addr=calcData_in`, `mem_wdata=wdata_in` and `mem_we=we_in`; go to WAIT.
  - `stall_out=1`, combinational from the IDLE state and the inputs.
  - Output regs load a bubble: `wbs_out=0`, `ni_out=1`, other outputs hold.
- **WAIT:**
  - `mem_req=1`; `mem_addr`, `mem_we` and `mem_wdata` stay stable.
  - `stall_out=1`; bubble into the output regs.
  - On `mem_ack=1`: capture `mem_rdata` into `rdata_q` (loads only) and go to DONE.
- **DONE:**
  - `mem_req=0`, `stall_out=0`.
  - Output regs load the frozen inputs: `wbs_in`, `calcData_in`, `ni_out=0`, and `memData_out=rdata_q` for a load or 0 for a store.
  - Go to IDLE.
- **Ignored ack:** `mem_ack` outside WAIT is ignored.
- **Reset:**
  - State IDLE; `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` = 0; `stall_out` = 0.
  - `wbs_out=0`, `memData_out=0`, `calcData_out=0`, `ni_out=1`, `err_out=0`.
  - Reset mid-WAIT drops `mem_req` on the next edge; the access is abandoned.

## Timing
- **Non-memory instruction:** latency 1 cycle to the output regs; full throughput; no stall.
- **Memory instruction accepted at cycle 0:**
  - `mem_req` is high from cycle 1.
  - Ack at cycle N (N≥1) → DONE at N+1 → outputs valid at N+2.
  - `stall_out` is high for cycles 0..N.
  - Minimum access cost: 2 stall cycles.
- **Back-to-back accesses:** the next access can be accepted in the IDLE cycle that follows DONE.
- **Ack timing:** `mem_ack` is sampled only on an edge where `mem_req=1`; `mem_rdata` is sampled on that same edge.

## Configuration
- **`MEM_TIMEOUT_EN` defined:**
  - A counter clears on WAIT entry and increments every WAIT cycle.
  - After TIMEOUT_CYCLES WAIT cycles with no ack, go to DONE with `rdata_q=16'hDEAD` and set `err_out=1`.
  - `err_out` stays high until `rst`.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- **`MEM_TIMEOUT_EN` undefined:**
  - No counter; WAIT lasts indefinitely until ack.
  - `err_out` is tied to 0.

## Structure
- **Shared package `cpu_mem_pkg`:**
  - `mem_state_t` enum {IDLE, WAIT, DONE}.
  - `DATA_W` default.
  - `TIMEOUT_DATA` = 16'hDEAD.
  - Bubble constant (`wbs=0`, `ni=1`).
- **Sub-module `mem_watchdog`:** wraps the timeout counter and the sticky error flag; instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- **Pass-through:** non-memory op `wbs_in=1`, `calcData_in=16'hABCD`, `ni_in=0` → next edge `wbs_out=1`, `calcData_out=ABCD`, `memData_out=0000`, `ni_out=0`, `stall_out=0`.
- **Load:** `re_in=1`, `calcData_in=16'h0010`, ack at cycle 3 with `mem_rdata=16'h1234` → `mem_addr=0010`, `mem_req` high cycles 1–3, `stall_out` high cycles 0–3, `ni_out=1` during stall, `memData_out=1234` and `ni_out=0` at cycle 5.
- **Store with read:** `we_in=1` and `re_in=1`, `wdata_in=16'h5678`, immediate ack → `mem_we=1`, `mem_wdata=5678`, `memData_out=0000`; exactly 2 stall cycles.
- **Reset mid-access:** `rst` pulsed during WAIT → `mem_req=0`, `stall_out=0`, `ni_out=1`, `err_out=0` on the next edge; a later stray `mem_ack` has no effect.
- **Timeout:** with `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`, no ack → after 4 WAIT cycles `memData_out=DEAD`, `err_out=1`, and `err_out` stays high across later accesses.
- **Bubble input:** `ni_in=1` with `re_in=1` → no `mem_req`, no stall, `ni_out=1`.
